// File: rtl/score_keeper_if.sv
// Event/score bundle between the board engine and game control (master) and score_keeper (slave).
interface score_keeper_if;
  logic        clr;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic [15:0] score;
  logic        score_inc;
  logic [7:0]  lines_total;
  logic [3:0]  level;
  logic [3:0]  combo;
  logic        busy;
  logic        drop_err;

  modport master (
    output clr, clear_valid, clear_lines,
    input  score, score_inc, lines_total, level, combo, busy, drop_err
  );

  modport slave (
    input  clr, clear_valid, clear_lines,
    output score, score_inc, lines_total, level, combo, busy, drop_err
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: digit-serial BCD scoring of line-clear events with a one-deep pending slot.
// Optional combo bonus is enabled by defining SCORE_COMBO_EN.
module score_keeper #(
  parameter logic [7:0] PTS1        = 8'h01,
  parameter logic [7:0] PTS2        = 8'h03,
  parameter logic [7:0] PTS3        = 8'h05,
  parameter logic [7:0] PTS4        = 8'h08,
  parameter int         COMBO_MAX   = 9,
  parameter int         LEVEL_LINES = 10
) (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_e;

  localparam logic [7:0] LevelDiv = 8'(LEVEL_LINES);

  // The combo bonus is a single BCD digit and the level divider must fit the line counter.
  if (COMBO_MAX < 0 || COMBO_MAX > 9 || LEVEL_LINES < 1 || LEVEL_LINES > 255) begin : g_bad_params
    $error("score_keeper: COMBO_MAX must be 0..9 and LEVEL_LINES 1..255");
  end

  state_e          state_q;
  logic [15:0]     score_q;
  logic [3:0][3:0] work_q;
  logic [7:0]      addend_q;
  logic [1:0]      digit_q;
  logic            carry_q;
  logic            pend_valid_q;
  logic [2:0]      pend_lines_q;
  logic [7:0]      lines_q;
  logic [3:0]      level_q;
  logic            score_inc_q;
  logic            drop_err_q;

  logic            take_pend_d;
  logic            take_new_d;
  logic            accept_d;
  logic            store_new_d;
  logic            drop_d;
  logic            pend_valid_d;
  logic [2:0]      acc_raw_d;
  logic [2:0]      acc_n_d;
  logic [7:0]      pts_d;
  logic [7:0]      addend_d;
  logic [8:0]      lines_sum_d;
  logic [7:0]      lines_d;
  logic [7:0]      level_quot_d;
  logic [3:0]      level_d;
  logic [3:0]      add_digit_d;
  logic [4:0]      wk_d;
  logic [3:0]      digit_d;
  logic            carry_d;

`ifdef SCORE_COMBO_EN
  localparam logic [3:0] ComboCap = 4'(COMBO_MAX);

  logic [3:0] combo_q;
  logic [3:0] combo_d;

  function automatic logic [7:0] bcd_bonus(input logic [7:0] pts, input logic [3:0] bonus);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = {1'b0, pts[3:0]} + {1'b0, bonus};
    hi = {1'b0, pts[7:4]};
    if (lo > 5'd9) begin
      lo = lo - 5'd10;
      hi = hi + 5'd1;
    end
    if (hi > 5'd9) begin
      return 8'h99;
    end
    return {hi[3:0], lo[3:0]};
  endfunction
`endif

  // Intake arbitration: a waiting event beats a new one, which then takes its place in the slot.
  always_comb begin
    take_pend_d  = (state_q == IDLE) && pend_valid_q;
    take_new_d   = (state_q == IDLE) && !pend_valid_q && bus.clear_valid;
    accept_d     = take_pend_d || take_new_d;
    store_new_d  = bus.clear_valid && !take_new_d && (!pend_valid_q || take_pend_d);
    drop_d       = bus.clear_valid && pend_valid_q && !take_pend_d;
    pend_valid_d = (pend_valid_q && !take_pend_d) || store_new_d;

    acc_raw_d = take_pend_d ? pend_lines_q : bus.clear_lines;
    acc_n_d   = (acc_raw_d > 3'd4) ? 3'd4 : acc_raw_d;

    case (acc_n_d)
      3'd1:    pts_d = PTS1;
      3'd2:    pts_d = PTS2;
      3'd3:    pts_d = PTS3;
      default: pts_d = PTS4;
    endcase

`ifdef SCORE_COMBO_EN
    addend_d = bcd_bonus(pts_d, combo_q);
    combo_d  = (combo_q >= ComboCap) ? ComboCap : combo_q + 4'd1;
`else
    addend_d = pts_d;
`endif

    lines_sum_d  = {1'b0, lines_q} + {6'd0, acc_n_d};
    lines_d      = lines_sum_d[8] ? 8'hFF : lines_sum_d[7:0];
    level_quot_d = lines_d / LevelDiv;
    level_d      = (level_quot_d > 8'd15) ? 4'd15 : level_quot_d[3:0];
  end

  // One BCD digit of work + addend per ADD cycle; the addend only has two digits.
  always_comb begin
    case (digit_q)
      2'd0:    add_digit_d = addend_q[3:0];
      2'd1:    add_digit_d = addend_q[7:4];
      default: add_digit_d = 4'd0;
    endcase
    wk_d    = {1'b0, work_q[digit_q]} + {1'b0, add_digit_d} + {4'd0, carry_q};
    carry_d = (wk_d > 5'd9);
    digit_d = carry_d ? 4'(wk_d - 5'd10) : wk_d[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      score_q      <= 16'h0000;
      work_q       <= 16'h0000;
      addend_q     <= 8'h00;
      digit_q      <= 2'd0;
      carry_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_lines_q <= 3'd0;
      lines_q      <= 8'd0;
      level_q      <= 4'd0;
      score_inc_q  <= 1'b0;
      drop_err_q   <= 1'b0;
`ifdef SCORE_COMBO_EN
      combo_q      <= 4'd0;
`endif
    end else if (bus.clr) begin
      state_q      <= IDLE;
      score_q      <= 16'h0000;
      work_q       <= 16'h0000;
      addend_q     <= 8'h00;
      digit_q      <= 2'd0;
      carry_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_lines_q <= 3'd0;
      lines_q      <= 8'd0;
      level_q      <= 4'd0;
      score_inc_q  <= 1'b0;
      drop_err_q   <= 1'b0;
`ifdef SCORE_COMBO_EN
      combo_q      <= 4'd0;
`endif
    end else begin
      score_inc_q  <= 1'b0;
      pend_valid_q <= pend_valid_d;
      if (store_new_d) begin
        pend_lines_q <= bus.clear_lines;
      end
      if (drop_d) begin
        drop_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (acc_n_d == 3'd0) begin
`ifdef SCORE_COMBO_EN
              combo_q <= 4'd0;
`endif
            end else begin
              addend_q <= addend_d;
              lines_q  <= lines_d;
              level_q  <= level_d;
              work_q   <= score_q;
              digit_q  <= 2'd0;
              carry_q  <= 1'b0;
              state_q  <= ADD;
`ifdef SCORE_COMBO_EN
              combo_q  <= combo_d;
`endif
            end
          end
        end

        ADD: begin
          work_q[digit_q] <= digit_d;
          carry_q         <= carry_d;
          digit_q         <= digit_q + 2'd1;
          // A carry out of the top digit means the score overflowed: pin it at 9999.
          if (digit_q == 2'd3) begin
            state_q <= COMMIT;
            if (carry_d) begin
              work_q <= 16'h9999;
            end
          end
        end

        COMMIT: begin
          score_q     <= work_q;
          score_inc_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.score       = score_q;
  assign bus.score_inc   = score_inc_q;
  assign bus.lines_total = lines_q;
  assign bus.level       = level_q;
  assign bus.busy        = (state_q != IDLE) || pend_valid_q;
  assign bus.drop_err    = drop_err_q;
`ifdef SCORE_COMBO_EN
  assign bus.combo       = combo_q;
`else
  assign bus.combo       = 4'd0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper; inputs are driven and outputs sampled on the falling edge.
module tb_score_keeper;

`ifdef SCORE_COMBO_EN
  localparam logic [15:0] ExpCombo1  = 16'd1;
  localparam logic [15:0] ExpPair    = 16'h0005;
  localparam logic [15:0] ExpComboP  = 16'd2;
  localparam logic [15:0] ExpNine    = 16'h0045;
  localparam logic [15:0] ExpTen     = 16'h0055;
  localparam logic [15:0] ExpCombo10 = 16'd9;
`else
  localparam logic [15:0] ExpCombo1  = 16'd0;
  localparam logic [15:0] ExpPair    = 16'h0004;
  localparam logic [15:0] ExpComboP  = 16'd0;
  localparam logic [15:0] ExpNine    = 16'h0009;
  localparam logic [15:0] ExpTen     = 16'h0010;
  localparam logic [15:0] ExpCombo10 = 16'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   passCount  = 0;
  int   checkCount = 0;

  score_keeper_if bus();

  score_keeper dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [2:0] lines);
    bus.clear_valid = 1'b1;
    bus.clear_lines = lines;
    @(negedge clk);
    bus.clear_valid = 1'b0;
    bus.clear_lines = 3'd0;
  endtask

  task automatic waitInc(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.score_inc !== 1'b1 && cycles < 20);
  endtask

  task automatic scoreEvent(input logic [2:0] lines, input string tag);
    int lat;
    applyStimulus(lines);
    waitInc(lat);
    checkOutput(tag, 16'(bus.score_inc), 16'd1);
  endtask

  task automatic pulseClr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic seenInc;

    reset           = 1'b1;
    bus.clr         = 1'b0;
    bus.clear_valid = 1'b0;
    bus.clear_lines = 3'd0;
    repeat (2) @(negedge clk);

    checkOutput("rst_score", bus.score, 16'h0000);
    checkOutput("rst_score_inc", 16'(bus.score_inc), 16'd0);
    checkOutput("rst_lines", 16'(bus.lines_total), 16'd0);
    checkOutput("rst_level", 16'(bus.level), 16'd0);
    checkOutput("rst_combo", 16'(bus.combo), 16'd0);
    checkOutput("rst_busy", 16'(bus.busy), 16'd0);
    checkOutput("rst_drop_err", 16'(bus.drop_err), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-line clear: latency, pulse width, counters.
    applyStimulus(3'd1);
    checkOutput("busy_after_accept", 16'(bus.busy), 16'd1);
    checkOutput("lines_at_accept", 16'(bus.lines_total), 16'd1);
    waitInc(lat);
    checkOutput("latency_cycles", 16'(lat), 16'd5);
    checkOutput("score_first", bus.score, 16'h0001);
    checkOutput("combo_first", 16'(bus.combo), ExpCombo1);
    @(negedge clk);
    checkOutput("score_inc_one_cycle", 16'(bus.score_inc), 16'd0);
    checkOutput("idle_after_commit", 16'(bus.busy), 16'd0);

    // Build 0098 with combo held at zero, then carry across digits.
    pulseClr();
    checkOutput("clr_score", bus.score, 16'h0000);
    checkOutput("clr_lines", 16'(bus.lines_total), 16'd0);
    for (int i = 0; i < 11; i++) begin
      scoreEvent(3'd4, "inc_build4");
      applyStimulus(3'd0);
    end
    scoreEvent(3'd3, "inc_build3a");
    applyStimulus(3'd0);
    scoreEvent(3'd3, "inc_build3b");
    applyStimulus(3'd0);
    checkOutput("score_0098", bus.score, 16'h0098);
    checkOutput("combo_zero_line", 16'(bus.combo), 16'd0);
    scoreEvent(3'd4, "inc_carry");
    checkOutput("score_0106", bus.score, 16'h0106);
    checkOutput("lines_54", 16'(bus.lines_total), 16'd54);
    checkOutput("level_5", 16'(bus.level), 16'd5);

    // Three back-to-back events: second waits in the slot, third is lost.
    pulseClr();
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd1;
    @(negedge clk);
    bus.clear_lines = 3'd2;
    @(negedge clk);
    bus.clear_lines = 3'd3;
    @(negedge clk);
    bus.clear_valid = 1'b0;
    bus.clear_lines = 3'd0;
    checkOutput("drop_err_set", 16'(bus.drop_err), 16'd1);
    checkOutput("busy_pending", 16'(bus.busy), 16'd1);
    waitInc(lat);
    checkOutput("inc_pair_first", 16'(bus.score_inc), 16'd1);
    checkOutput("score_pair_first", bus.score, 16'h0001);
    waitInc(lat);
    checkOutput("inc_pair_second", 16'(bus.score_inc), 16'd1);
    checkOutput("score_pair_final", bus.score, ExpPair);
    checkOutput("lines_pair", 16'(bus.lines_total), 16'd3);
    checkOutput("combo_pair", 16'(bus.combo), ExpComboP);
    checkOutput("drop_err_sticky", 16'(bus.drop_err), 16'd1);
    @(negedge clk);
    checkOutput("busy_pair_done", 16'(bus.busy), 16'd0);

    // Ten single-line clears: level boundary, then a 0-line lock.
    pulseClr();
    checkOutput("clr_drop_err", 16'(bus.drop_err), 16'd0);
    for (int i = 0; i < 9; i++) begin
      scoreEvent(3'd1, "inc_single");
    end
    checkOutput("score_nine", bus.score, ExpNine);
    checkOutput("level_at_9", 16'(bus.level), 16'd0);
    scoreEvent(3'd1, "inc_single10");
    checkOutput("score_ten", bus.score, ExpTen);
    checkOutput("lines_10", 16'(bus.lines_total), 16'd10);
    checkOutput("level_at_10", 16'(bus.level), 16'd1);
    checkOutput("combo_ten", 16'(bus.combo), ExpCombo10);
    applyStimulus(3'd0);
    checkOutput("combo_reset_zero", 16'(bus.combo), 16'd0);
    seenInc = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seenInc = seenInc | bus.score_inc;
    end
    checkOutput("no_inc_zero_line", 16'(seenInc), 16'd0);
    checkOutput("score_zero_line", bus.score, ExpTen);
    checkOutput("lines_zero_line", 16'(bus.lines_total), 16'd10);

    // clr during digit 2 aborts the add and overrides a simultaneous event.
    applyStimulus(3'd1);
    @(negedge clk);
    @(negedge clk);
    bus.clr         = 1'b1;
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd4;
    @(negedge clk);
    bus.clr         = 1'b0;
    bus.clear_valid = 1'b0;
    bus.clear_lines = 3'd0;
    checkOutput("abort_score", bus.score, 16'h0000);
    checkOutput("abort_busy", 16'(bus.busy), 16'd0);
    checkOutput("abort_lines", 16'(bus.lines_total), 16'd0);
    checkOutput("abort_inc", 16'(bus.score_inc), 16'd0);
    seenInc = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seenInc = seenInc | bus.score_inc;
    end
    checkOutput("abort_no_inc", 16'(seenInc), 16'd0);
    checkOutput("abort_score_after", bus.score, 16'h0000);

    // Long climb with clear_lines=7 (treated as 4), then saturation at 9999.
    for (int i = 0; i < 1249; i++) begin
      scoreEvent(3'd7, "inc_climb");
      applyStimulus(3'd0);
    end
    checkOutput("score_9992", bus.score, 16'h9992);
    checkOutput("lines_sat", 16'(bus.lines_total), 16'd255);
    checkOutput("level_sat", 16'(bus.level), 16'd15);
    scoreEvent(3'd2, "inc_9995");
    applyStimulus(3'd0);
    checkOutput("score_9995", bus.score, 16'h9995);
    scoreEvent(3'd4, "inc_saturate");
    checkOutput("score_9999", bus.score, 16'h9999);
    applyStimulus(3'd0);
    scoreEvent(3'd1, "inc_at_max");
    checkOutput("score_stays_9999", bus.score, 16'h9999);
    @(negedge clk);
    checkOutput("inc_at_max_one_cycle", 16'(bus.score_inc), 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly upstream of the game control block and consumes line-clear events from the board engine.
- Keeps a 4-digit BCD score, a cleared-line total, a level and a combo count.
- Emits the `score` bus and a one-cycle `score_inc` pulse; control uses that pulse to extend its countdown and reset its gravity speed-up.
- BCD addition is digit-serial: one digit per cycle, through a small FSM with a one-deep pending slot.

Parameters:
- PTS1, 8'h01, BCD points for a 1-line clear
- PTS2, 8'h03, BCD points for a 2-line clear
- PTS3, 8'h05, BCD points for a 3-line clear
- PTS4, 8'h08, BCD points for a 4-line clear
- COMBO_MAX, 9, combo counter saturation value (binary, ≤9)
- LEVEL_LINES, 10, cleared lines per level step

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous game-restart clear (driven from control `start` low)
- clear_valid  in  1  one-cycle pulse: a piece locked
- clear_lines  in  3  lines removed by that lock (0..4; values >4 are treated as 4)
- score  out  16  BCD score, digit 0 in [3:0]
- score_inc  out  1  one-cycle pulse when a nonzero score update commits
- lines_total  out  8  binary total of cleared lines, saturating at 255
- level  out  4  min(lines_total / LEVEL_LINES, 15)
- combo  out  4  consecutive-clearing locks, capped at COMBO_MAX
- busy  out  1  FSM not in IDLE, or pending slot full
- drop_err  out  1  sticky: an event was lost because the pending slot was full

Behaviour:
- Async reset clears everything to 0: score, lines_total, level, combo, busy, drop_err, score_inc, FSM=IDLE, pending empty.
- `clr` is synchronous and performs the same clear; it overrides a `clear_valid` in the same cycle.
- Event intake:
  - If FSM is IDLE and pending is empty, the event is accepted directly.
  - Otherwise it is stored in the pending slot.
  - If pending is already full, the event is discarded and drop_err is set.
  - Pending is accepted on the first IDLE cycle; it takes priority over a new event in that cycle, and the new event goes to pending.
- On accept with clear_lines=0: combo←0, no score change, no score_inc, FSM stays IDLE.
- On accept with n≥1:
  - addend = PTSn (+ combo value before increment, only with SCORE_COMBO_EN; BCD add, capped at 8'h99).
  - combo←min(combo+1, COMBO_MAX).
  - lines_total←sat(lines_total+n); level recomputed the same edge.
  - FSM→ADD, digit index=0, working register←score, carry=0.
- ADD state (4 cycles, digit k=0..3):
  - wk = work[k] + addend_digit[k] + carry; addend digits 2,3 are 0.
  - If wk>9: digit = wk−10 and carry=1, else carry=0.
  - Digit k is written into the working register only.
- After k=3: FSM→COMMIT.
  - If the final carry is 1, the result saturates to 16'h9999.
  - score←work.
  - score_inc is high for exactly the next cycle.
  - FSM→IDLE.
- Latency: accept edge T → score visible and score_inc high in cycle T+5.
- `score` never shows a partially added value.
- score_inc is never asserted for 0-line events.
- score at 16'h9999 plus any addend stays 16'h9999; score_inc still pulses.
- Events are processed in arrival order.
- Asserting `clr` in mid-ADD aborts the addition; the result is not committed and there is no score_inc.

Optional Feature:
- SCORE_COMBO_EN defined: the combo bonus is added to the addend as described above.
- Undefined: no bonus is added; combo logic is removed and `combo` is tied to 0. Intake, latency and score_inc timing are unchanged.

Test Plan:
- Reset, then clear_valid with lines=1 → score=16'h0001 at T+5; score_inc high one cycle; lines_total=1; combo=1.
- score=16'h0098, 4-line clear, combo 0 → score=16'h0106 (carry across digits 0→1→2).
- score=16'h9995, 4-line clear → score=16'h9999 (saturated); score_inc pulses.
- Three clear_valid events (lines 1,2,3) on consecutive cycles from IDLE → the first two are processed in order, the third is dropped with drop_err=1; final score=16'h0004 without combo, 16'h0005 with SCORE_COMBO_EN.
- 10 single-line clears → lines_total=10, level=1; a following 0-line lock → combo=0, no score_inc.
- `clr` asserted during ADD digit 2 → score=0 next cycle, no score_inc, FSM=IDLE, busy=0.
